stream_tx: RTL and testbench
============================

Name: stream_tx

Overview:
- Block-buffered AXI-Stream-style transmitter: the source end of the valid/last stream that the sorter stages consume.
- Software/testbench side writes a run of up to DEPTH words into an internal buffer.
- On `start`, the block emits the run in write order on out/valid_out/last_out, honouring downstream `ready` backpressure.
- Sits at the head of the mergesort pipeline, feeding the first pair-sort stage.

Parameters:
- DATA_W, 32, word width (matches `DATA_W in def.h).
- DEPTH, 16, buffer capacity in words; power of two, at least 2.
- ADDR_W, 4, log2(DEPTH).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- wr_en  input  1  write strobe, fill side.
- wr_data  input  DATA_W  word to buffer.
- wr_full  output  1  buffer holds DEPTH words; writes are dropped.
- start  input  1  single-cycle request to transmit the buffered run.
- busy  output  1  high while in SEND.
- done  output  1  one-cycle pulse after the final word is accepted.
- out  output  DATA_W  stream data.
- valid_out  output  1  stream valid.
- last_out  output  1  marks the final word of the run.
- ready  input  1  downstream ready.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: out=0, valid_out=0, last_out=0, busy=0, done=0, wr_full=0. Word count and read pointer are 0, state=FILL. Buffer contents are don't-care.
- Transfer occurs on a cycle with valid_out & ready. valid_out never depends combinationally on ready.
- While valid_out=1 and ready=0, out and last_out hold stable.
- States:
  - FILL: accepts writes.
  - SEND: streams the run.
  - DONE: single cycle; done=1; returns to FILL.
- FILL:
  - wr_en with count<DEPTH stores wr_data at mem[count] and increments count.
  - wr_en with count==DEPTH is dropped; wr_full=1 whenever count==DEPTH.
- FILL + start:
  - Run length = count, plus 1 if wr_en is accepted in the same cycle; the simultaneous write is included as the final word.
  - Run length 0: start is ignored; stay in FILL; no done pulse.
  - Otherwise go to SEND. Next cycle: valid_out=1, out=word0. Latency start→first valid is 1 cycle.
- SEND:
  - On each transfer, rd_ptr advances and the next word appears the following cycle. Throughput is 1 word/cycle with ready held high.
  - last_out=1 exactly while the presented word is index length-1. A run of length 1 presents valid_out and last_out together.
  - On the final transfer: next cycle valid_out=0, last_out=0, state=DONE.
- Ignored inputs: wr_en and start are ignored in SEND and DONE.
- Completion: on DONE→FILL, count and rd_ptr clear to 0 (see optional feature).
- rst mid-SEND: outputs return to reset values the next cycle; the run is abandoned; no done pulse.
- Pointers are ADDR_W bits; count is ADDR_W+1 bits, so DEPTH itself is representable. No wrap-around within a run.

Optional Feature:
- Macro: STREAM_TX_REPLAY_EN.
- Defined:
  - Adds input port `clear` (1 bit).
  - DONE→FILL retains count and buffer contents, so a later start re-sends the identical run.
  - Writes in FILL append after the retained words.
  - clear in FILL zeroes count in one cycle. clear has priority over wr_en and start in the same cycle; clear is ignored outside FILL.
- Undefined: no `clear` port; the buffer empties automatically after every run, as described above.

Decomposition:
- Shared header def.h holds:
  - DATA_W.
  - State encodings FILL=2'b00, SEND=2'b01, DONE=2'b10.
  - DEPTH/ADDR_W defaults.
- One sub-module, stream_tx_mem:
  - DEPTH×DATA_W register file.
  - One synchronous write port, one asynchronous read port.
- stream_tx holds the FSM, counters and registered outputs.

Test Plan:
- Basic run: write 5,3,9 then start; ready=1 → out=5,3,9 on consecutive cycles, last_out only with 9, done pulse one cycle after the 9 transfer, wr_full=0.
- Backpressure: write 4 words (1,2,3,4); after first valid, drop ready for 3 cycles → out holds 2 and valid_out holds 1; the stream resumes and completes with no loss or duplication.
- Full and edge starts:
  - Write 17 words 0..16 → wr_full=1 after the 16th; word 16 is dropped; transmitted run is 0..15 with last on 15.
  - start with an empty buffer → no valid_out, no done.
- Simultaneous and ignored inputs:
  - After writing 7,8, assert wr_en(11) together with start → run 7,8,11, last on 11.
  - wr_en/start during SEND have no effect.
- Reset mid-run: rst during the 2nd word of a 4-word run → next cycle valid_out=0, busy=0; a fresh 1-word run (42) gives valid_out and last_out together.
- With STREAM_TX_REPLAY_EN: write 6,1 and send; start again → 6,1 re-sent. Then clear, write 9, start → run is 9 only.

Source files
------------

// File: rtl/stream_tx_pkg.sv
// stream_tx_pkg: shared definitions for the stream_tx block.
//   DEF_DATA_W / DEF_DEPTH / DEF_ADDR_W : default word width and buffer geometry
//   state_e                             : transmitter FSM encoding
package stream_tx_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 16;
  localparam int DEF_ADDR_W = 4;

  typedef enum logic [1:0] {
    FILL = 2'b00,
    SEND = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/stream_tx_mem.sv
// stream_tx_mem: DEPTH x DATA_W register file holding the run to transmit.
//   clk            : clock, rising edge
//   we/waddr/wdata : synchronous write port
//   raddr/rdata    : asynchronous (combinational) read port
// Contents have no reset; only words below the fill count are ever read.
module stream_tx_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk) mem_q <= mem_d;

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/stream_tx.sv
// stream_tx: block-buffered valid/last stream transmitter.
//   clk, rst    : clock and synchronous active-high reset
//   wr_en/wr_data, wr_full : fill side; writes beyond DEPTH words are dropped
//   start       : request to transmit the buffered run
//   busy, done  : busy while sending; done pulses once after the final transfer
//   out/valid_out/last_out, ready : stream side, transfer on valid_out & ready
// Optional: STREAM_TX_REPLAY_EN adds input `clear`; the buffer is then kept
// after each run (start re-sends it, writes append) until `clear` empties it.
module stream_tx
  import stream_tx_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
`ifdef STREAM_TX_REPLAY_EN
  input  logic              clear,
`endif
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_full,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] out,
  output logic              valid_out,
  output logic              last_out,
  input  logic              ready
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  state_e              state_q, state_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0]   out_q, out_d;
  logic                valid_q, valid_d;
  logic                last_q, last_d;

  logic                full, clr, wr_acc, mem_we;
  logic [ADDR_W:0]     run_len;
  logic [ADDR_W-1:0]   raddr;
  logic [DATA_W-1:0]   rdata;

`ifdef STREAM_TX_REPLAY_EN
  assign clr = clear && (state_q == FILL);
`else
  assign clr = 1'b0;
`endif

  assign full    = (count_q == FULL_CNT);
  assign wr_acc  = (state_q == FILL) && wr_en && !full && !clr;
  assign run_len = count_q + (ADDR_W+1)'(wr_acc);

  stream_tx_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (count_q[ADDR_W-1:0]),
    .wdata (wr_data),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    out_d    = out_q;
    valid_d  = valid_q;
    last_d   = last_q;
    mem_we   = 1'b0;
    raddr    = '0;
    case (state_q)
      FILL: begin
        if (clr) begin
          count_d = '0;
        end else begin
          if (wr_acc) begin
            mem_we  = 1'b1;
            count_d = count_q + 1'b1;
          end
          if (start && run_len != '0) begin
            state_d  = SEND;
            rd_ptr_d = '0;
            valid_d  = 1'b1;
            last_d   = (run_len == (ADDR_W+1)'(1));
            // Word 0 is still being written when the buffer was empty, so
            // bypass the register file in that case.
            out_d    = (count_q == '0) ? wr_data : rdata;
          end
        end
      end
      SEND: begin
        // Read port looks one word ahead of the presented word.
        raddr = rd_ptr_q + 1'b1;
        if (valid_q && ready) begin
          if (last_q) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            state_d = DONE;
          end else begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            out_d    = rdata;
            last_d   = ({1'b0, rd_ptr_q} + (ADDR_W+1)'(2)) == count_q;
          end
        end
      end
      DONE: begin
        state_d  = FILL;
        rd_ptr_d = '0;
`ifndef STREAM_TX_REPLAY_EN
        count_d  = '0;
`endif
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FILL;
      count_q  <= '0;
      rd_ptr_q <= '0;
      out_q    <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      out_q    <= out_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
    end
  end

  assign out       = out_q;
  assign valid_out = valid_q;
  assign last_out  = last_q;
  assign busy      = (state_q == SEND);
  assign done      = (state_q == DONE);
  assign wr_full   = full;

endmodule

// File: tb/tb_stream_tx.sv
// tb_stream_tx: self-checking bench for stream_tx (scoreboard + vector table).
module tb_stream_tx;

  localparam int DW = 32;
  localparam int DEPTH = 16;

  logic clk = 0, rst = 1, wr_en = 0, start = 0, ready = 1;
  logic [DW-1:0] wr_data = '0;
  logic wr_full, busy, done, valid_out, last_out;
  logic [DW-1:0] out;
`ifdef STREAM_TX_REPLAY_EN
  logic clear = 0;
`endif

  stream_tx dut (
    .clk(clk), .rst(rst),
`ifdef STREAM_TX_REPLAY_EN
    .clear(clear),
`endif
    .wr_en(wr_en), .wr_data(wr_data), .wr_full(wr_full),
    .start(start), .busy(busy), .done(done),
    .out(out), .valid_out(valid_out), .last_out(last_out), .ready(ready)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int cyc = 0, last_cyc = 0;
  logic [DW:0] sb[$];  // {last, data}

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Scoreboard: every transfer seen on the stream pops one expected word.
  always @(negedge clk) begin
    if (!rst && valid_out && ready) begin
      if (sb.size() == 0) chk("extra word", {31'b0, last_out, out}, 64'hdead);
      else begin
        logic [DW:0] e;
        e = sb.pop_front();
        chk("stream word", {31'b0, last_out, out}, {31'b0, e});
      end
      if (last_out) last_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_write(input logic [DW-1:0] d);
    wr_en = 1; wr_data = d; tick(); wr_en = 0;
  endtask

  task automatic clear_buf();
`ifdef STREAM_TX_REPLAY_EN
    clear = 1; tick(); clear = 0;
`endif
  endtask

  task automatic wait_done(input string nm);
    bit seen = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done) begin seen = 1; break; end
    end
    chk({nm, " done seen"}, seen, 1);
    if (seen) chk({nm, " done latency"}, cyc - last_cyc, 1);
    @(negedge clk);
    chk({nm, " done width"}, done, 0);
    chk({nm, " idle"}, busy, 0);
    chk({nm, " sb empty"}, sb.size(), 0);
  endtask

  typedef struct packed {
    logic [4:0] n;        // words written
    logic       simul;    // last write issued with start
    logic [4:0] exp_len;  // expected transmitted run length
    logic [19:0][DW-1:0] w;
  } vec_t;

  vec_t tbl[4];

  task automatic run_vec(input vec_t v, input string nm);
    int nf;
    nf = v.simul ? int'(v.n) - 1 : int'(v.n);
    for (int i = 0; i < nf; i++) begin
      do_write(v.w[i]);
      chk({nm, " wr_full"}, wr_full, (i + 1 >= DEPTH));
    end
    for (int i = 0; i < int'(v.exp_len); i++)
      sb.push_back({(i == int'(v.exp_len) - 1), v.w[i]});
    start = 1;
    if (v.simul) begin wr_en = 1; wr_data = v.w[v.n-1]; end
    tick();
    start = 0; wr_en = 0;
    @(negedge clk);
    chk({nm, " first valid"}, valid_out, 1);
    chk({nm, " busy"}, busy, 1);
    chk({nm, " first last"}, last_out, (v.exp_len == 1));
    wait_done(nm);
  endtask

  initial begin
    tbl[0] = '0; tbl[0].n = 3; tbl[0].exp_len = 3;
    tbl[0].w[0] = 5; tbl[0].w[1] = 3; tbl[0].w[2] = 9;
    tbl[1] = '0; tbl[1].n = 17; tbl[1].exp_len = 16;
    for (int i = 0; i < 17; i++) tbl[1].w[i] = DW'(i);
    tbl[2] = '0; tbl[2].n = 3; tbl[2].simul = 1; tbl[2].exp_len = 3;
    tbl[2].w[0] = 7; tbl[2].w[1] = 8; tbl[2].w[2] = 11;
    tbl[3] = '0; tbl[3].n = 1; tbl[3].exp_len = 1; tbl[3].w[0] = 42;

    // reset state
    repeat (2) tick();
    @(negedge clk);
    chk("rst out", out, 0);
    chk("rst valid", valid_out, 0);
    chk("rst last", last_out, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst wr_full", wr_full, 0);
    rst = 0;
    tick();

    for (int t = 0; t < 3; t++) begin
      clear_buf();
      run_vec(tbl[t], $sformatf("vec%0d", t));
    end

    // backpressure: hold word 2 for three cycles
    clear_buf();
    for (int i = 1; i <= 4; i++) begin
      do_write(DW'(i));
      sb.push_back({(i == 4), DW'(i)});
    end
    start = 1; tick(); start = 0;
    tick();            // word 1 transferred
    ready = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp valid", valid_out, 1);
      chk("bp out", out, 2);
      chk("bp last", last_out, 0);
      tick();
    end
    ready = 1;
    wait_done("bp");

    // start with empty buffer
    clear_buf();
    start = 1; tick(); start = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("empty valid", valid_out, 0);
      chk("empty done", done, 0);
      chk("empty busy", busy, 0);
    end

    // wr_en/start during SEND are ignored
    clear_buf();
    for (int i = 1; i <= 3; i++) begin
      do_write(DW'(i));
      sb.push_back({(i == 3), DW'(i)});
    end
    start = 1; tick();
    wr_en = 1; wr_data = 99;
    tick(); tick();
    start = 0; wr_en = 0;
    wait_done("ignore");

    // reset mid-run: word 10 goes out, then reset while 20 is presented
    clear_buf();
    for (int i = 1; i <= 4; i++) do_write(DW'(10 * i));
    sb.push_back({1'b0, DW'(10)});
    start = 1; tick(); start = 0;
    tick();
    ready = 0;
    @(negedge clk);
    chk("pre-rst out", out, 20);
    rst = 1; tick(); rst = 0;
    @(negedge clk);
    chk("mid-rst valid", valid_out, 0);
    chk("mid-rst busy", busy, 0);
    chk("mid-rst last", last_out, 0);
    chk("mid-rst out", out, 0);
    chk("mid-rst sb", sb.size(), 0);
    ready = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("mid-rst no done", done, 0);
    end
    run_vec(tbl[3], "single");

`ifdef STREAM_TX_REPLAY_EN
    clear_buf();
    do_write(6); do_write(1);
    sb.push_back({1'b0, DW'(6)}); sb.push_back({1'b1, DW'(1)});
    start = 1; tick(); start = 0;
    wait_done("replay1");
    sb.push_back({1'b0, DW'(6)}); sb.push_back({1'b1, DW'(1)});
    start = 1; tick(); start = 0;
    wait_done("replay2");
    // clear wins over a simultaneous start
    clear = 1; start = 1; tick(); clear = 0; start = 0;
    @(negedge clk);
    chk("clear blocks start", valid_out, 0);
    do_write(9);
    sb.push_back({1'b1, DW'(9)});
    start = 1; tick(); start = 0;
    wait_done("replay3");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
